// File: rtl/lh1_pkg.sv
// rtl/lh1_pkg.sv - shared types and timing constants for the lh1 sync decoder
//
// Purpose: shared FSM state enum, pulse class enum, error codes and default
// timing constants for a 48 MHz receive clock.
// Ports: none (package).

package lh1_pkg;

  localparam int DEF_WIDTH         = 16;
  localparam int DEF_TS_WIDTH      = 20;
  localparam int DEF_SYNC_BASE     = 2750;
  localparam int DEF_SYNC_STEP     = 500;
  localparam int DEF_SWEEP_MAX     = 1200;
  localparam int DEF_SWEEP_TIMEOUT = 400000;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CLS_BAD   = 2'd0,
    CLS_SWEEP = 2'd1,
    CLS_SYNC  = 2'd2
  } pulse_class_e;

  localparam logic [1:0] ERR_BAD_WIDTH = 2'd1;
  localparam logic [1:0] ERR_ORPHAN    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

endpackage

// File: rtl/lighthouse_width_classifier.sv
// rtl/lighthouse_width_classifier.sv - registered pulse width classifier (stage 1)
//
// Purpose: one cycle after pulse_done, presents the pulse class (sweep, sync,
// bad), the 3-bit sync code and the pulse start timestamp (ts - width).
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   pulse_done        strobe, pulse_width valid this cycle
//   pulse_width       measured pulse length in ticks
//   ts                free-running timestamp
//   s1_valid          strobe, stage-1 result valid
//   s1_class          pulse class
//   s1_code           sync code 0..7 (meaningful for CLS_SYNC only)
//   s1_start          timestamp of the pulse leading edge

module lighthouse_width_classifier
  import lh1_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int TS_WIDTH  = DEF_TS_WIDTH,
  parameter int SYNC_BASE = DEF_SYNC_BASE,
  parameter int SYNC_STEP = DEF_SYNC_STEP,
  parameter int SWEEP_MAX = DEF_SWEEP_MAX
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pulse_done,
  input  logic [WIDTH-1:0]    pulse_width,
  input  logic [TS_WIDTH-1:0] ts,
  output logic                s1_valid,
  output pulse_class_e        s1_class,
  output logic [2:0]          s1_code,
  output logic [TS_WIDTH-1:0] s1_start
);

  logic [31:0]  width_ext;
  pulse_class_e class_d;
  logic [2:0]   code_d;

  assign width_ext = 32'(pulse_width);

  // Code k is the count of step boundaries above SYNC_BASE that the width has
  // reached; a compare chain keeps this divider-free.
  always_comb begin
    class_d = CLS_BAD;
    code_d  = 3'd0;
    if (width_ext <= 32'(SWEEP_MAX)) begin
      class_d = CLS_SWEEP;
    end else if (width_ext >= 32'(SYNC_BASE) &&
                 width_ext <  32'(SYNC_BASE + 8 * SYNC_STEP)) begin
      class_d = CLS_SYNC;
      for (int k = 1; k < 8; k++) begin
        if (width_ext >= 32'(SYNC_BASE + k * SYNC_STEP)) begin
          code_d = 3'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_class <= CLS_BAD;
      s1_code  <= 3'd0;
      s1_start <= '0;
    end else begin
      s1_valid <= pulse_done;
      if (pulse_done) begin
        s1_class <= class_d;
        s1_code  <= code_d;
        s1_start <= ts - TS_WIDTH'(pulse_width);
      end
    end
  end

endmodule

// File: rtl/lighthouse_sync_decoder.sv
// rtl/lighthouse_sync_decoder.sv - lh1 sync/sweep decoder and sweep timer
//
// Purpose: classifies completed pulses, decodes sync skip/data/axis bits,
// and measures sweep time from the last armed sync start to the sweep start.
// All strobes assert exactly two cycles after pulse_done.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   pulse_done        strobe, pulse_width valid this cycle
//   pulse_width       measured pulse length in ticks
//   sync_valid        strobe, sync decoded; sync_skip/data/axis hold between
//   sweep_valid       strobe, sweep measured; sweep_ticks/axis hold between
//   armed             high while waiting for a sweep
//   err_valid         strobe, err_code: 1 bad width, 2 orphan sweep, 3 timeout

module lighthouse_sync_decoder
  import lh1_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int TS_WIDTH      = DEF_TS_WIDTH,
  parameter int SYNC_BASE     = DEF_SYNC_BASE,
  parameter int SYNC_STEP     = DEF_SYNC_STEP,
  parameter int SWEEP_MAX     = DEF_SWEEP_MAX,
  parameter int SWEEP_TIMEOUT = DEF_SWEEP_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pulse_done,
  input  logic [WIDTH-1:0]    pulse_width,
  output logic                sync_valid,
  output logic                sync_skip,
  output logic                sync_data,
  output logic                sync_axis,
  output logic                sweep_valid,
  output logic [TS_WIDTH-1:0] sweep_ticks,
  output logic                sweep_axis,
  output logic                armed,
  output logic                err_valid,
  output logic [1:0]          err_code
);

  localparam logic [TS_WIDTH-1:0] TIMEOUT_TS = TS_WIDTH'(SWEEP_TIMEOUT);

  logic [TS_WIDTH-1:0] ts;
  logic                s1_valid;
  pulse_class_e        s1_class;
  logic [2:0]          s1_code;
  logic [TS_WIDTH-1:0] s1_start;

  state_e              state_q, state_d;
  logic [TS_WIDTH-1:0] sync_start_q, sync_start_d;
  logic                armed_axis_q, armed_axis_d;

  logic                sync_valid_d;
  logic [2:0]          sync_bits_d;
  logic                sweep_valid_d;
  logic [TS_WIDTH-1:0] sweep_ticks_d;
  logic                sweep_axis_d;
  logic                err_valid_d;
  logic [1:0]          err_code_d;
  logic [TS_WIDTH-1:0] elapsed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  lighthouse_width_classifier #(
    .WIDTH     (WIDTH),
    .TS_WIDTH  (TS_WIDTH),
    .SYNC_BASE (SYNC_BASE),
    .SYNC_STEP (SYNC_STEP),
    .SWEEP_MAX (SWEEP_MAX)
  ) u_classifier (
    .clk         (clk),
    .reset       (reset),
    .pulse_done  (pulse_done),
    .pulse_width (pulse_width),
    .ts          (ts),
    .s1_valid    (s1_valid),
    .s1_class    (s1_class),
    .s1_code     (s1_code),
    .s1_start    (s1_start)
  );

  // Modular distance from the armed sync start; wraps cleanly with ts.
  assign elapsed = ts - sync_start_q;

  always_comb begin
    state_d       = state_q;
    sync_start_d  = sync_start_q;
    armed_axis_d  = armed_axis_q;
    sync_valid_d  = 1'b0;
    sync_bits_d   = {sync_skip, sync_data, sync_axis};
    sweep_valid_d = 1'b0;
    sweep_ticks_d = sweep_ticks;
    sweep_axis_d  = sweep_axis;
    err_valid_d   = 1'b0;
    err_code_d    = err_code;

    if (s1_valid) begin
      // A pulse this cycle wins over the timeout, which is re-checked later.
      case (s1_class)
        CLS_SYNC: begin
          sync_valid_d = 1'b1;
          sync_bits_d  = s1_code;
          if (!s1_code[2]) begin
            state_d      = ARMED;
            sync_start_d = s1_start;
            armed_axis_d = s1_code[0];
          end
        end
        CLS_SWEEP: begin
          if (state_q == ARMED) begin
            sweep_valid_d = 1'b1;
            sweep_ticks_d = s1_start - sync_start_q;
            sweep_axis_d  = armed_axis_q;
            state_d       = IDLE;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_ORPHAN;
          end
        end
        default: begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_BAD_WIDTH;
        end
      endcase
    end else if (state_q == ARMED && elapsed >= TIMEOUT_TS) begin
      state_d     = IDLE;
      err_valid_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sync_start_q <= '0;
      armed_axis_q <= 1'b0;
      sync_valid   <= 1'b0;
      sync_skip    <= 1'b0;
      sync_data    <= 1'b0;
      sync_axis    <= 1'b0;
      sweep_valid  <= 1'b0;
      sweep_ticks  <= '0;
      sweep_axis   <= 1'b0;
      err_valid    <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      state_q      <= state_d;
      sync_start_q <= sync_start_d;
      armed_axis_q <= armed_axis_d;
      sync_valid   <= sync_valid_d;
      sync_skip    <= sync_bits_d[2];
      sync_data    <= sync_bits_d[1];
      sync_axis    <= sync_bits_d[0];
      sweep_valid  <= sweep_valid_d;
      sweep_ticks  <= sweep_ticks_d;
      sweep_axis   <= sweep_axis_d;
      err_valid    <= err_valid_d;
      err_code     <= err_code_d;
    end
  end

  assign armed = (state_q == ARMED);

endmodule

// File: tb/tb_lighthouse_sync_decoder.sv
// tb/tb_lighthouse_sync_decoder.sv - directed self-checking bench for lighthouse_sync_decoder

module tb_lighthouse_sync_decoder;

  localparam int TSW     = 14;
  localparam int TSMASK  = (1 << TSW) - 1;
  localparam int TIMEOUT = 9000;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            pulse_done = 1'b0;
  logic [15:0]     pulse_width = 16'd0;
  logic            sync_valid, sync_skip, sync_data, sync_axis;
  logic            sweep_valid, sweep_axis, armed, err_valid;
  logic [TSW-1:0]  sweep_ticks;
  logic [1:0]      err_code;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lighthouse_sync_decoder #(
    .WIDTH         (16),
    .TS_WIDTH      (TSW),
    .SYNC_BASE     (2750),
    .SYNC_STEP     (500),
    .SWEEP_MAX     (1200),
    .SWEEP_TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pulse_done  (pulse_done),
    .pulse_width (pulse_width),
    .sync_valid  (sync_valid),
    .sync_skip   (sync_skip),
    .sync_data   (sync_data),
    .sync_axis   (sync_axis),
    .sweep_valid (sweep_valid),
    .sweep_ticks (sweep_ticks),
    .sweep_axis  (sweep_axis),
    .armed       (armed),
    .err_valid   (err_valid),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  // Reference tick count; equals the DUT timestamp modulo 2^TSW.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send(input int w);
    pulse_done  = 1'b1;
    pulse_width = 16'(w);
    @(negedge clk);
    pulse_done  = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic [31:0] bits();
    return 32'({sync_skip, sync_data, sync_axis});
  endfunction

  int t, a, b, tgt;
  int ws[6]    = '{2749, 2750, 3249, 3250, 6749, 6750};
  int wbad[6]  = '{1, 0, 0, 0, 0, 1};
  int wcode[6] = '{0, 0, 0, 1, 7, 0};

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sync_valid",  32'(sync_valid), 32'd0);
    check("rst_armed",       32'(armed), 32'd0);
    check("rst_err_valid",   32'(err_valid), 32'd0);
    check("rst_sweep_ticks", 32'(sweep_ticks), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Sync code 0 then sweep 5000 ticks later.
    t = cyc;
    send(3000);
    @(negedge clk);
    check("t1_sync_valid", 32'(sync_valid), 32'd1);
    check("t1_sync_bits",  bits(), 32'd0);
    check("t1_armed",      32'(armed), 32'd1);
    wait_until(t + 5000);
    send(500);
    @(negedge clk);
    check("t1_sweep_valid", 32'(sweep_valid), 32'd1);
    check("t1_sweep_ticks", 32'(sweep_ticks), 32'd7500);
    check("t1_sweep_axis",  32'(sweep_axis), 32'd0);
    check("t1_armed_low",   32'(armed), 32'd0);

    // Width boundaries around the sync code table.
    a = 0;
    for (int i = 0; i < 6; i++) begin
      if (ws[i] == 3250) a = cyc;
      send(ws[i]);
      @(negedge clk);
      check($sformatf("tbl_err_%0d", ws[i]), 32'(err_valid), 32'(wbad[i]));
      if (wbad[i] == 1) check($sformatf("tbl_code_%0d", ws[i]), 32'(err_code), 32'd1);
      else              check($sformatf("tbl_sync_%0d", ws[i]), bits(), 32'(wcode[i]));
    end

    // Sweep boundary widths: 1200 sweep, 1201 bad, 0 sweep (orphan now).
    b = cyc;
    send(1200);
    @(negedge clk);
    check("w1200_sweep_valid", 32'(sweep_valid), 32'd1);
    check("w1200_ticks", 32'(sweep_ticks), 32'(((b - 1200) - (a - 3250)) & TSMASK));
    check("w1200_axis",  32'(sweep_axis), 32'd1);
    send(1201);
    @(negedge clk);
    check("w1201_err",  32'(err_valid), 32'd1);
    check("w1201_code", 32'(err_code), 32'd1);
    send(0);
    @(negedge clk);
    check("w0_sweep_valid", 32'(sweep_valid), 32'd0);
    check("w0_err_code",    32'(err_code), 32'd2);

    // Skip sync leaves the FSM idle; following sweep is an orphan.
    send(5000);
    @(negedge clk);
    check("skip_sync_valid", 32'(sync_valid), 32'd1);
    check("skip_bits",       bits(), 32'd4);
    check("skip_armed",      32'(armed), 32'd0);
    send(400);
    @(negedge clk);
    check("orphan_err",   32'(err_valid), 32'd1);
    check("orphan_code",  32'(err_code), 32'd2);
    check("orphan_sweep", 32'(sweep_valid), 32'd0);

    // Timeout: start = t-3500, fires when ts - start reaches TIMEOUT.
    t = cyc;
    send(3500);
    @(negedge clk);
    check("to_bits",  bits(), 32'd1);
    check("to_armed", 32'(armed), 32'd1);
    wait_until(t - 3500 + TIMEOUT);
    check("to_early_err", 32'(err_valid), 32'd0);
    check("to_early_arm", 32'(armed), 32'd1);
    @(negedge clk);
    check("to_err",   32'(err_valid), 32'd1);
    check("to_code",  32'(err_code), 32'd3);
    check("to_armed_low", 32'(armed), 32'd0);

    // Timestamp wrap between sync and sweep.
    tgt = (cyc | TSMASK) - 99;
    if (tgt < cyc) tgt = tgt + (1 << TSW);
    wait_until(tgt);
    send(3000);
    wait_until(tgt + 5000);
    send(300);
    @(negedge clk);
    check("wrap_sweep_valid", 32'(sweep_valid), 32'd1);
    check("wrap_ticks",       32'(sweep_ticks), 32'd7700);

    // Back-to-back sync then sweep.
    pulse_done  = 1'b1;
    pulse_width = 16'd3000;
    @(negedge clk);
    pulse_width = 16'd300;
    @(negedge clk);
    pulse_done  = 1'b0;
    check("b2b_sync_valid",  32'(sync_valid), 32'd1);
    check("b2b_sweep_early", 32'(sweep_valid), 32'd0);
    @(negedge clk);
    check("b2b_sweep_valid", 32'(sweep_valid), 32'd1);
    check("b2b_ticks",       32'(sweep_ticks), 32'd2701);
    check("b2b_armed",       32'(armed), 32'd0);

    // Reset while armed clears outputs immediately.
    send(3000);
    @(negedge clk);
    check("pre_rst_armed", 32'(armed), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_armed", 32'(armed), 32'd0);
    check("async_rst_sync",  32'(sync_valid), 32'd0);
    check("async_rst_ticks", 32'(sweep_ticks), 32'd0);
    check("async_rst_code",  32'(err_code), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(300);
    @(negedge clk);
    check("post_rst_err",   32'(err_valid), 32'd1);
    check("post_rst_code",  32'(err_code), 32'd2);
    check("post_rst_sweep", 32'(sweep_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
